// File: rtl/qpu_itcm_icb_arbt_pkg.sv
// Shared constants for the ITCM ICB arbiter.
// Width of the ICB address and SRAM line, plus response-owner encodings and
// the request/grant bit positions used by the 2-way arbiter.
package qpu_itcm_icb_arbt_pkg;

  localparam int QPU_ITCM_ADDR_WIDTH = 16;
  localparam int QPU_ITCM_DATA_WIDTH = 64;
  localparam int QPU_ITCM_MASK_WIDTH = QPU_ITCM_DATA_WIDTH / 8;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  // Bit positions inside the req/gnt vectors of qpu_itcm_arb2.
  localparam int IDX_IFU = 0;
  localparam int IDX_EXT = 1;

endpackage

// File: rtl/qpu_gnrl_dfflr.sv
// General load-enable flop with asynchronous active-low reset to zero.
// Ports:
//   i_lden  - load enable
//   i_dnxt  - next value
//   o_qout  - registered value
//   clk     - clock
//   rst_n   - async reset, active low
module qpu_gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          i_lden,
  input  logic [DW-1:0] i_dnxt,
  output logic [DW-1:0] o_qout,
  input  logic          clk,
  input  logic          rst_n
);

  logic [DW-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_lden) begin
      r_q <= i_dnxt;
    end
  end

  assign o_qout = r_q;

endmodule

// File: rtl/qpu_itcm_arb2.sv
// Two-way alternating-priority arbiter.
// A lone requester always wins; on contention the side that did not win the
// previous grant is chosen, so neither requester can starve the other.
// Ports:
//   i_req      - request vector, bit IDX_IFU / IDX_EXT
//   i_en       - arbitration enable (no grant when low)
//   i_last_ext - previous grant went to EXT
//   o_gnt      - one-hot (or zero) grant vector
module qpu_itcm_arb2
  import qpu_itcm_icb_arbt_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  logic       i_last_ext,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req[IDX_IFU] && i_req[IDX_EXT]) begin
        o_gnt[IDX_IFU] = i_last_ext;
        o_gnt[IDX_EXT] = ~i_last_ext;
      end else begin
        o_gnt = i_req;
      end
    end
  end

endmodule

// File: rtl/qpu_itcm_icb_arbt.sv
// ITCM ICB arbiter: shares the single-port ITCM SRAM between the IFU fetch
// port (read-only) and the host ICB port (read/write). One access is issued
// per grant, read data returns one cycle later straight from the SRAM output,
// and at most one response is outstanding. A new command can issue in the
// same cycle the outstanding response handshakes.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   ifu_icb_cmd_*/rsp_*     - IFU fetch ICB (read only)
//   ext_icb_cmd_*/rsp_*     - host ICB (read/write, byte mask)
//   ram_cs/we/addr/wem/din  - SRAM command side (addr is a line index)
//   ram_dout                - SRAM read data, held while ram_cs=0
//   ifu_holdup              - SRAM output still holds the last IFU line
module qpu_itcm_icb_arbt
  import qpu_itcm_icb_arbt_pkg::*;
#(
  parameter int ITCM_ADDR_WIDTH = QPU_ITCM_ADDR_WIDTH,
  parameter int ITCM_DATA_WIDTH = QPU_ITCM_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         ifu_icb_cmd_valid,
  output logic                         ifu_icb_cmd_ready,
  input  logic [ITCM_ADDR_WIDTH-1:0]   ifu_icb_cmd_addr,
  output logic                         ifu_icb_rsp_valid,
  input  logic                         ifu_icb_rsp_ready,
  output logic [ITCM_DATA_WIDTH-1:0]   ifu_icb_rsp_rdata,

  input  logic                         ext_icb_cmd_valid,
  output logic                         ext_icb_cmd_ready,
  input  logic [ITCM_ADDR_WIDTH-1:0]   ext_icb_cmd_addr,
  input  logic                         ext_icb_cmd_read,
  input  logic [ITCM_DATA_WIDTH-1:0]   ext_icb_cmd_wdata,
  input  logic [ITCM_DATA_WIDTH/8-1:0] ext_icb_cmd_wmask,
  output logic                         ext_icb_rsp_valid,
  input  logic                         ext_icb_rsp_ready,
  output logic [ITCM_DATA_WIDTH-1:0]   ext_icb_rsp_rdata,

  output logic                         ram_cs,
  output logic                         ram_we,
  output logic [ITCM_ADDR_WIDTH-4:0]   ram_addr,
  output logic [ITCM_DATA_WIDTH/8-1:0] ram_wem,
  output logic [ITCM_DATA_WIDTH-1:0]   ram_din,
  input  logic [ITCM_DATA_WIDTH-1:0]   ram_dout,

  output logic                         ifu_holdup
);

  logic       w_rsp_pend;
  logic       w_rsp_owner;
  logic       w_last_ext;
  logic       w_holdup;

  logic       w_rsp_hsk;
  logic       w_can_issue;
  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_gnt_ifu;
  logic       w_gnt_ext;
  logic       w_gnt_any;
  logic       w_addr_lsb_unused;

  assign w_rsp_hsk   = (ifu_icb_rsp_valid & ifu_icb_rsp_ready)
                     | (ext_icb_rsp_valid & ext_icb_rsp_ready);
  assign w_can_issue = ~w_rsp_pend | w_rsp_hsk;

  assign w_req[IDX_IFU] = ifu_icb_cmd_valid;
  assign w_req[IDX_EXT] = ext_icb_cmd_valid;

  qpu_itcm_arb2 u_arb2 (
    .i_req      (w_req),
    .i_en       (w_can_issue),
    .i_last_ext (w_last_ext),
    .o_gnt      (w_gnt)
  );

  assign w_gnt_ifu = w_gnt[IDX_IFU];
  assign w_gnt_ext = w_gnt[IDX_EXT];
  assign w_gnt_any = w_gnt_ifu | w_gnt_ext;

  assign ifu_icb_cmd_ready = w_gnt_ifu;
  assign ext_icb_cmd_ready = w_gnt_ext;

  // SRAM command side
  assign ram_cs   = w_gnt_any;
  assign ram_we   = w_gnt_ext & ~ext_icb_cmd_read;
  assign ram_addr = w_gnt_ext ? ext_icb_cmd_addr[ITCM_ADDR_WIDTH-1:3]
                              : ifu_icb_cmd_addr[ITCM_ADDR_WIDTH-1:3];
  assign ram_wem  = ram_we ? ext_icb_cmd_wmask : '0;
  assign ram_din  = ext_icb_cmd_wdata;

  // Byte-within-line bits are resolved by the fetch path, not here.
  assign w_addr_lsb_unused = ^{ifu_icb_cmd_addr[2:0], ext_icb_cmd_addr[2:0]};

  // Pending flag: set by any grant, cleared by a handshake with no new grant.
  qpu_gnrl_dfflr #(.DW(1)) u_rsp_pend (
    .i_lden (w_gnt_any | w_rsp_hsk),
    .i_dnxt (w_gnt_any),
    .o_qout (w_rsp_pend),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  qpu_gnrl_dfflr #(.DW(1)) u_rsp_owner (
    .i_lden (w_gnt_any),
    .i_dnxt (w_gnt_ext ? OWNER_EXT : OWNER_IFU),
    .o_qout (w_rsp_owner),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  qpu_gnrl_dfflr #(.DW(1)) u_last_ext (
    .i_lden (w_gnt_any),
    .i_dnxt (w_gnt_ext),
    .o_qout (w_last_ext),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  // Any EXT access (read or write) overwrites the SRAM output register,
  // so only an IFU grant leaves the fetched line in place.
  qpu_gnrl_dfflr #(.DW(1)) u_holdup (
    .i_lden (w_gnt_any),
    .i_dnxt (w_gnt_ifu),
    .o_qout (w_holdup),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  assign ifu_holdup = w_holdup;

  // Response side: rdata comes straight from the SRAM, which holds its
  // output while ram_cs is low, so no data register is needed.
  assign ifu_icb_rsp_valid = w_rsp_pend & (w_rsp_owner == OWNER_IFU);
  assign ext_icb_rsp_valid = w_rsp_pend & (w_rsp_owner == OWNER_EXT);
  assign ifu_icb_rsp_rdata = ram_dout;
  assign ext_icb_rsp_rdata = ram_dout;

endmodule

// File: tb/tb_qpu_itcm_icb_arbt.sv
module tb_qpu_itcm_icb_arbt;

  localparam int AW    = 16;
  localparam int DW    = 64;
  localparam int LINES = 1 << (AW - 3);

  logic          clk;
  logic          rst_n;
  logic          ifu_icb_cmd_valid;
  logic          ifu_icb_cmd_ready;
  logic [AW-1:0] ifu_icb_cmd_addr;
  logic          ifu_icb_rsp_valid;
  logic          ifu_icb_rsp_ready;
  logic [DW-1:0] ifu_icb_rsp_rdata;
  logic          ext_icb_cmd_valid;
  logic          ext_icb_cmd_ready;
  logic [AW-1:0] ext_icb_cmd_addr;
  logic          ext_icb_cmd_read;
  logic [DW-1:0] ext_icb_cmd_wdata;
  logic [7:0]    ext_icb_cmd_wmask;
  logic          ext_icb_rsp_valid;
  logic          ext_icb_rsp_ready;
  logic [DW-1:0] ext_icb_rsp_rdata;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-4:0] ram_addr;
  logic [7:0]    ram_wem;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ifu_holdup;

  qpu_itcm_icb_arbt #(.ITCM_ADDR_WIDTH(AW), .ITCM_DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ifu_icb_cmd_valid (ifu_icb_cmd_valid),
    .ifu_icb_cmd_ready (ifu_icb_cmd_ready),
    .ifu_icb_cmd_addr  (ifu_icb_cmd_addr),
    .ifu_icb_rsp_valid (ifu_icb_rsp_valid),
    .ifu_icb_rsp_ready (ifu_icb_rsp_ready),
    .ifu_icb_rsp_rdata (ifu_icb_rsp_rdata),
    .ext_icb_cmd_valid (ext_icb_cmd_valid),
    .ext_icb_cmd_ready (ext_icb_cmd_ready),
    .ext_icb_cmd_addr  (ext_icb_cmd_addr),
    .ext_icb_cmd_read  (ext_icb_cmd_read),
    .ext_icb_cmd_wdata (ext_icb_cmd_wdata),
    .ext_icb_cmd_wmask (ext_icb_cmd_wmask),
    .ext_icb_rsp_valid (ext_icb_rsp_valid),
    .ext_icb_rsp_ready (ext_icb_rsp_ready),
    .ext_icb_rsp_rdata (ext_icb_rsp_rdata),
    .ram_cs            (ram_cs),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_wem           (ram_wem),
    .ram_din           (ram_din),
    .ram_dout          (ram_dout),
    .ifu_holdup        (ifu_holdup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM: 1-cycle read, output held while cs=0.
  logic [DW-1:0] sram [LINES];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++)
          if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= sram[ram_addr];
      end
    end
  end

  // Transaction-level reference: expected memory contents, outstanding
  // responses in order, who won last, and whether the SRAM output still
  // holds an IFU line.
  typedef struct {
    bit            is_ext;
    bit            is_read;
    logic [DW-1:0] data;
  } txn_t;

  logic [DW-1:0] ref_mem [LINES];
  txn_t          pend_q[$];
  bit            m_last_ext;
  bit            m_holdup;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [7:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Evaluate one cycle against the model at the falling edge, then advance.
  task automatic step();
    bit   exp_ifu_v, exp_ext_v, hsk, can, win_ifu, win_ext;
    int   line;
    txn_t t;
    @(negedge clk);
    exp_ifu_v = (pend_q.size() != 0) && !pend_q[0].is_ext;
    exp_ext_v = (pend_q.size() != 0) &&  pend_q[0].is_ext;
    check_eq("ifu_rsp_valid", ifu_icb_rsp_valid, exp_ifu_v);
    check_eq("ext_rsp_valid", ext_icb_rsp_valid, exp_ext_v);
    check_eq("ifu_holdup", ifu_holdup, m_holdup);
    if (exp_ifu_v && pend_q[0].is_read) check_eq("ifu_rdata", ifu_icb_rsp_rdata, pend_q[0].data);
    if (exp_ext_v && pend_q[0].is_read) check_eq("ext_rdata", ext_icb_rsp_rdata, pend_q[0].data);
    hsk = (exp_ifu_v && ifu_icb_rsp_ready) || (exp_ext_v && ext_icb_rsp_ready);
    can = (pend_q.size() == 0) || hsk;
    win_ifu = 0;
    win_ext = 0;
    if (can) begin
      if (ifu_icb_cmd_valid && ext_icb_cmd_valid) begin
        if (m_last_ext) win_ifu = 1; else win_ext = 1;
      end else begin
        win_ifu = ifu_icb_cmd_valid;
        win_ext = ext_icb_cmd_valid;
      end
    end
    check_eq("ifu_cmd_ready", ifu_icb_cmd_ready, win_ifu);
    check_eq("ext_cmd_ready", ext_icb_cmd_ready, win_ext);
    check_eq("ram_cs", ram_cs, win_ifu | win_ext);
    if (hsk) void'(pend_q.pop_front());
    if (win_ifu) begin
      line = int'(ifu_icb_cmd_addr >> 3);
      check_eq("ram_addr_ifu", ram_addr, line);
      check_eq("ram_we_ifu", ram_we, 1'b0);
      check_eq("ram_wem_ifu", ram_wem, 8'h00);
      t.is_ext = 0; t.is_read = 1; t.data = ref_mem[line];
      pend_q.push_back(t);
      m_last_ext = 0;
      m_holdup   = 1;
    end
    if (win_ext) begin
      line = int'(ext_icb_cmd_addr >> 3);
      check_eq("ram_addr_ext", ram_addr, line);
      check_eq("ram_we_ext", ram_we, !ext_icb_cmd_read);
      check_eq("ram_wem_ext", ram_wem, ext_icb_cmd_read ? 8'h00 : ext_icb_cmd_wmask);
      if (!ext_icb_cmd_read) check_eq("ram_din", ram_din, ext_icb_cmd_wdata);
      t.is_ext = 1; t.is_read = ext_icb_cmd_read; t.data = ref_mem[line];
      pend_q.push_back(t);
      if (!ext_icb_cmd_read)
        ref_mem[line] = merge(ref_mem[line], ext_icb_cmd_wdata, ext_icb_cmd_wmask);
      m_last_ext = 1;
      m_holdup   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ifu_icb_cmd_valid = 0;
    ifu_icb_cmd_addr  = '0;
    ifu_icb_rsp_ready = 1;
    ext_icb_cmd_valid = 0;
    ext_icb_cmd_addr  = '0;
    ext_icb_cmd_read  = 1;
    ext_icb_cmd_wdata = '0;
    ext_icb_cmd_wmask = '0;
    ext_icb_rsp_ready = 1;
  endtask

  task automatic drive_rand();
    ifu_icb_cmd_valid = ($urandom_range(0, 3) != 0);
    ifu_icb_cmd_addr  = AW'($urandom_range(0, 255));
    ifu_icb_rsp_ready = ($urandom_range(0, 3) != 0);
    ext_icb_cmd_valid = ($urandom_range(0, 2) != 0);
    ext_icb_cmd_addr  = AW'($urandom_range(0, 255));
    ext_icb_cmd_read  = $urandom_range(0, 1);
    ext_icb_cmd_wdata = {$urandom, $urandom};
    ext_icb_cmd_wmask = 8'($urandom);
    ext_icb_rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_reset();
    pend_q.delete();
    m_last_ext = 0;
    m_holdup   = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < LINES; i++) begin
      sram[i]    = {$urandom, $urandom};
      ref_mem[i] = sram[i];
    end
    ram_dout = '0;
    set_idle();
    model_reset();
    rst_n = 0;
    #12;
    check_eq("rst_ram_cs", ram_cs, 1'b0);
    check_eq("rst_ifu_ready", ifu_icb_cmd_ready, 1'b0);
    check_eq("rst_ext_ready", ext_icb_cmd_ready, 1'b0);
    check_eq("rst_ifu_rsp_valid", ifu_icb_rsp_valid, 1'b0);
    check_eq("rst_ext_rsp_valid", ext_icb_rsp_valid, 1'b0);
    check_eq("rst_holdup", ifu_holdup, 1'b0);
    #5 rst_n = 1;
    @(posedge clk); #1;

    // IFU read at 0x0010 -> line 2, response next cycle, holdup set
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0010;
    step();
    set_idle();
    step();
    step();

    // Contention every cycle: strict alternation starting with EXT
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0040;
    ext_icb_cmd_valid = 1; ext_icb_cmd_addr = 16'h0080; ext_icb_cmd_read = 1;
    repeat (6) step();
    set_idle();
    step();

    // EXT masked write at 0x0008, then IFU reads the merged line
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0020;
    step();
    set_idle();
    ext_icb_cmd_valid = 1; ext_icb_cmd_addr = 16'h0008; ext_icb_cmd_read = 0;
    ext_icb_cmd_wdata = 64'hA5A5_A5A5_A5A5_A5A5; ext_icb_cmd_wmask = 8'h0F;
    step();
    set_idle();
    step();
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h000C;
    step();
    set_idle();
    step();

    // IFU response stalled 3 cycles while EXT waits; EXT issues on handshake
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0018; ifu_icb_rsp_ready = 0;
    step();
    ifu_icb_cmd_valid = 0;
    ext_icb_cmd_valid = 1; ext_icb_cmd_addr = 16'h0030; ext_icb_cmd_read = 1;
    repeat (3) step();
    ifu_icb_rsp_ready = 1;
    step();
    set_idle();
    step();

    // IFU read, idle 5 cycles with holdup kept, then EXT read clears it
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0050;
    step();
    set_idle();
    repeat (5) step();
    ext_icb_cmd_valid = 1; ext_icb_cmd_addr = 16'h0058; ext_icb_cmd_read = 1;
    step();
    set_idle();
    step();

    // Reset while a response is pending
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0060; ifu_icb_rsp_ready = 0;
    step();
    ifu_icb_cmd_valid = 0;
    rst_n = 0;
    #1;
    check_eq("midrst_ifu_rsp_valid", ifu_icb_rsp_valid, 1'b0);
    check_eq("midrst_ext_rsp_valid", ext_icb_rsp_valid, 1'b0);
    check_eq("midrst_holdup", ifu_holdup, 1'b0);
    check_eq("midrst_ram_cs", ram_cs, 1'b0);
    model_reset();
    set_idle();
    @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    ifu_icb_cmd_valid = 1; ifu_icb_cmd_addr = 16'h0068;
    step();
    set_idle();
    step();
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
    end
    set_idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
